// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared FSM states and line levels for uart_tx_frame (BREAK state under UART_TX_BREAK_EN)
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP_1 = 3'd4,
    STOP_2 = 3'd5
`ifdef UART_TX_BREAK_EN
    ,
    BREAK  = 3'd6
`endif
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_shifter.sv
// rtl/uart_tx_shifter.sv - data shift register, data bit counter and parity for uart_tx_frame
module uart_tx_shifter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  ser,
  output logic                  parity,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sh_q;
  logic [CW-1:0]         cnt_q;
  logic                  par_q;

  // Capture the word on load; each shift exposes the next data bit and advances the counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh_q  <= '0;
      cnt_q <= '0;
      par_q <= 1'b0;
    end else if (load) begin
      sh_q  <= p_data;
      cnt_q <= '0;
      par_q <= ^p_data;
    end else if (shift) begin
      sh_q <= {1'b0, sh_q[DATA_WIDTH-1:1]};
      if (cnt_q != LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (done) begin
      // The last data bit is on the line and no shift is requested: the FSM is leaving DATA
      cnt_q <= '0;
    end
  end

  // ser is the data bit the line will carry after this edge
  assign ser    = shift ? sh_q[1] : sh_q[0];
  assign parity = par_q;
  assign done   = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter, one bit per clock; UART_TX_BREAK_EN adds BRK input and BREAK state
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = STOP_BIT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic                  BRK,
`endif
  output logic                  TX_OUT,
  output logic                  BUSY
);

  tx_state_e state_q, state_d;
  logic      tx_d;
  logic      load, shift;
  logic      ser, par, done;
  logic      par_en_q, par_typ_q, stop2_q;

  uart_tx_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
    .CLK    (CLK),
    .RST    (RST),
    .load   (load),
    .shift  (shift),
    .p_data (P_DATA),
    .ser    (ser),
    .parity (par),
    .done   (done)
  );

  // Next state, next line level and shifter controls; the line level is chosen for the cycle after the edge
  always_comb begin
    state_d = state_q;
    tx_d    = IDLE_LEVEL;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (BRK) begin
          state_d = BREAK;
          tx_d    = ~IDLE_LEVEL;
        end else
`endif
        if (DATA_VALID) begin
          state_d = START;
          tx_d    = START_BIT;
          load    = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        tx_d    = ser;
      end
      DATA: begin
        if (!done) begin
          shift = 1'b1;
          tx_d  = ser;
        end else if (par_en_q) begin
          state_d = PARITY;
          tx_d    = par ^ par_typ_q;
        end else begin
          state_d = STOP_1;
        end
      end
      PARITY: begin
        state_d = STOP_1;
      end
      STOP_1: begin
        if (stop2_q) begin
          state_d = STOP_2;
        end else if (DATA_VALID) begin
          state_d = START;
          tx_d    = START_BIT;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      STOP_2: begin
        if (DATA_VALID) begin
          state_d = START;
          tx_d    = START_BIT;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        // STOP_2 is always a single final stop cycle, so it doubles as the post-break stop
        if (BRK) begin
          tx_d = ~IDLE_LEVEL;
        end else begin
          state_d = STOP_2;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, registered serial line and the frame configuration captured at acceptance
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      TX_OUT    <= IDLE_LEVEL;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      TX_OUT  <= tx_d;
      if (load) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q   <= STOP2;
      end
    end
  end

  assign BUSY = (state_q != IDLE);

endmodule
